// File: rtl/exhaustive_stim_sequencer_pkg.sv
// exhaustive_stim_sequencer_pkg: shared FSM state type and MISR constants.
//   state_e   : sweep FSM states
//   MISR_POLY : feedback polynomial x^16+x^12+x^5+1
//   MISR_SEED : signature value at reset and at sweep start
package exhaustive_stim_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_e;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
endpackage

// File: rtl/exhaustive_stim_sequencer_misr16.sv
// misr16: 16-bit serial-input signature register.
//   CK     : clock
//   reset  : async active-low reset, loads MISR_SEED
//   seed_i : synchronous seed load, takes priority over shifting
//   en_i   : shift enable
//   d_i    : serial data in
//   sig_o  : current signature
module misr16
  import exhaustive_stim_sequencer_pkg::*;
(
  input  logic        CK,
  input  logic        reset,
  input  logic        seed_i,
  input  logic        en_i,
  input  logic        d_i,
  output logic [15:0] sig_o
);
  logic [15:0] sig_q;
  logic        fb;
  assign fb = sig_q[15] ^ d_i;
  always_ff @(posedge CK or negedge reset)
    if (!reset) sig_q <= MISR_SEED;
    else if (seed_i) sig_q <= MISR_SEED;
    else if (en_i) sig_q <= {sig_q[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
  assign sig_o = sig_q;
endmodule

// File: rtl/exhaustive_stim_sequencer.sv
// exhaustive_stim_sequencer: walks every WIDTH-bit pattern, holds each SETTLE
// cycles, captures the CUT response per pattern and compresses it in a MISR.
//   CK, reset              : clock, async active-low reset
//   start, abort           : begin sweep (IDLE only) / terminate sweep
//   resp_in                : single-bit CUT response
//   golden_sig             : expected signature, compared in DONE
//   pat_out                : stimulus to the CUT
//   busy, done             : sweep in progress / one-cycle completion pulse
//   resp_vec, signature    : captured responses and their MISR signature
//   pass, aborted          : signature match result / sticky abort flag
module exhaustive_stim_sequencer
  import exhaustive_stim_sequencer_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  CK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  resp_in,
  input  logic [15:0]           golden_sig,
  output logic [WIDTH-1:0]      pat_out,
  output logic                  busy,
  output logic                  done,
  output logic [2**WIDTH-1:0]   resp_vec,
  output logic [15:0]           signature,
  output logic                  pass,
  output logic                  aborted
);
  localparam int              N          = 2**WIDTH;
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
  localparam logic [WIDTH-1:0] LAST      = '1;
  state_e           state_q;
  logic [WIDTH-1:0] pat_out_q;
  logic [3:0]       cnt_q;
  logic [N-1:0]     resp_vec_q;
  logic             busy_q, done_q, pass_q, aborted_q;
  logic             misr_seed, misr_en;
  // The MISR follows the FSM: seeded on an accepted start, shifted on every
  // non-aborted SAMPLE cycle.
  assign misr_seed = (state_q == ST_IDLE) && start;
  assign misr_en   = (state_q == ST_SAMPLE) && !abort;
  misr16 u_misr (
    .CK     (CK),
    .reset  (reset),
    .seed_i (misr_seed),
    .en_i   (misr_en),
    .d_i    (resp_in),
    .sig_o  (signature)
  );
  always_ff @(posedge CK or negedge reset)
    if (!reset) begin
      state_q    <= ST_IDLE;
      pat_out_q  <= '0;
      cnt_q      <= '0;
      resp_vec_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE:
          if (start) begin
            pat_out_q  <= '0;
            cnt_q      <= SETTLE_CNT;
            resp_vec_q <= '0;
            pass_q     <= 1'b0;
            aborted_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SETTLE;
          end
        ST_SETTLE:
          if (abort) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= ST_SAMPLE;
          end
        ST_SAMPLE:
          if (abort) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            resp_vec_q[pat_out_q] <= resp_in;
            if (pat_out_q == LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              pat_out_q <= pat_out_q + 1'b1;
              cnt_q     <= SETTLE_CNT;
              state_q   <= ST_SETTLE;
            end
          end
        ST_DONE: begin
          pass_q  <= (signature == golden_sig);
          state_q <= ST_IDLE;
        end
      endcase
    end
  assign pat_out  = pat_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign resp_vec = resp_vec_q;
  assign pass     = pass_q;
  assign aborted  = aborted_q;
endmodule
